// File: rtl/opl3_pkg.sv
// Shared package: state encoding and widths used by the PISO block.
// Holds the PISO state enum and the frame counter width.
package opl3_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int FRAME_COUNT_WIDTH = 16;

endpackage

// File: rtl/pipeline_piso.sv
// Parallel-in serial-out frame sender; word 0 leaves first.
// Ports: clk, reset (sync, active-high), load_valid/load_ready/load_data
// (frame handshake), out_valid/out_ready/out_data/out_index/out_last
// (word handshake). Define PIPELINE_PISO_FRAME_COUNT_EN to add
// frame_count, a wrapping 16-bit count of completed frames.
module pipeline_piso
    import opl3_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_WORDS  = 18,
    parameter logic [DATA_WIDTH-1:0] POR_VALUE  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] load_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [$clog2(NUM_WORDS)-1:0]         out_index,
    output logic                                 out_last
`ifdef PIPELINE_PISO_FRAME_COUNT_EN
    ,
    output logic [FRAME_COUNT_WIDTH-1:0]         frame_count
`endif
);

    localparam int INDEX_WIDTH = $clog2(NUM_WORDS);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX =
        INDEX_WIDTH'(NUM_WORDS - 1);

    piso_state_e state;
    piso_state_e state_next;

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] frame;
    logic [INDEX_WIDTH-1:0]               index;
    logic                                 load_fire;
    logic                                 out_fire;

    // load_ready looks at out_ready only on the last beat, so a new
    // frame can replace the old one with no idle cycle in between.
    always_comb begin
        state_next = state;
        out_valid  = (state == SHIFT);
        out_last   = out_valid && (index == LAST_INDEX);
        load_ready = (state == IDLE) || (out_last && out_ready);
        load_fire  = load_valid && load_ready;
        out_fire   = out_valid && out_ready;
        case (state)
            IDLE: begin
                if (load_fire) state_next = SHIFT;
            end
            SHIFT: begin
                if (out_fire && out_last)
                    state_next = load_fire ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // The presented word is always frame[0], a register output, so
    // out_data has no combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame <= {NUM_WORDS{POR_VALUE}};
            index <= '0;
        end else if (load_fire) begin
            frame <= load_data;
            index <= '0;
        end else if (out_fire) begin
            for (int i = 0; i < NUM_WORDS - 1; i++)
                frame[i] <= frame[i+1];
            frame[NUM_WORDS-1] <= POR_VALUE;
            index <= out_last ? '0 : index + INDEX_WIDTH'(1);
        end
    end

    assign out_data  = frame[0];
    assign out_index = index;

`ifdef PIPELINE_PISO_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            frame_count <= '0;
        else if (out_fire && out_last)
            frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
    end
`endif

endmodule
